ucie_mlink_manager: RTL
=======================

// Module: ucie_mlink_manager
// PURPOSE
//  Multi-module UCIe D2D link manager. One shared training FSM (RESET..ACTIVE, RETRAIN, REPAIR, L1, L2, ERROR)
//  drives NUM_MODULES PHY modules; it advances only when every enabled module reports done, and masks out modules that time out.
//  Adds a valid/ready-correct sideband parameter exchange, parametrised timeouts, a bounded retry budget and L1/L2 entry/exit.
//  Sits between the D2D adapter and the per-module PHY training engines.
// PARAMETERS
//  NUM_MODULES    4        PHY modules managed (1..8)
//  MIN_MODULES    1        fewest enabled modules allowed before ERROR
//  TMR_W          24       state timer width; timer saturates at all-ones
//  TO_INIT        100000   SBINIT/PARAM/MBINIT/LINKINIT timeout, cycles
//  TO_TRAIN       2000000  CAL/MBTRAIN/RETRAIN/REPAIR timeout, cycles
//  RETRY_MAX      3        recoveries allowed before ERROR
//  STABLE_CYC     4096     ACTIVE dwell that clears the retry count
// PORTS
//  clk               in   1               clock
//  rst_n             in   1               async active-low reset
//  link_train_start  in   1               start/restart training; wake from L1/L2
//  cfg_max_width     in   8               local width cap
//  cfg_max_speed     in   8               local speed cap
//  phy_reset_ack     in   NUM_MODULES     per-module sideband up
//  phy_status        in   NUM_MODULES*8   per-module {rsvd[2:0],repair,linkrdy,trn,cal,mbrdy}
//  phy_cmd           out  8               broadcast train command
//  phy_reset_req     out  1               PHY reset request
//  module_en         out  NUM_MODULES     live (non-masked) modules
//  param_tx_data     out  32              {width,speed,module_en pad'1,8'hA5}
//  param_tx_valid    out  1               tx valid
//  param_tx_ready    in   1               tx ready
//  param_rx_data     in   32              rx params
//  param_rx_valid    in   1               rx valid
//  param_rx_ready    out  1               rx ready
//  error_vector      in   8               [0] CRC, [1] lane, others fatal
//  pm_req            in   2               01 = L1, 10 = L2, else none
//  pm_ack            out  1               one-cycle pulse on L1/L2 entry
//  link_state        out  4               link_state_t encoding
//  link_active       out  1               current state == ACTIVE
//  negotiated_width  out  8               min(local, remote)
//  negotiated_speed  out  8               min(local, remote)
//  retry_count       out  3               recoveries since the last stable ACTIVE
//  timeout_module    out  NUM_MODULES     sticky masked-by-timeout bits
// BEHAVIOUR
//  Reset: state RESET; module_en all ones; counters, negotiated values and timeout_module 0;
//   valid/ready/pm_ack 0; phy_reset_req 1; phy_cmd 0.
//  cfg_* are sampled when leaving RESET; they are not sampled at reset.
//  Done condition for stage k: &(stat_k | ~module_en), where stat_k is bit k of each module's phy_status.
//  Transitions:
//   RESET -start-> SBINIT -&(ack|~en)-> PARAM -both handshakes done-> MBINIT -mbrdy-> CAL -cal-> MBTRAIN
//   MBTRAIN -trn-> LINKINIT -linkrdy-> ACTIVE.
//  Timeout in a training stage: modules whose bit is still low get their module_en cleared and timeout_module set;
//   the state and timer restart. If popcount(module_en) < MIN_MODULES, go to ERROR.
//  PARAM:
//   - tx_valid stays high until tx_ready is seen, then drops; rx_ready stays high until rx_valid is seen, then drops.
//   - Capture happens on the rx handshake. Negotiation is the min of local and the captured remote value,
//     registered the cycle after capture.
//   - Exit when both handshakes are done (either order or in the same cycle); a timeout goes to ERROR.
//  ACTIVE:
//   - Any error_vector bit set in a cycle -> recovery.
//   - Bits[7:2] -> ERROR. Else bit0 -> RETRAIN. Else bit1 -> REPAIR.
//   - If bit0 and bit1 are set together, RETRAIN wins.
//   - If retry_count == RETRY_MAX, go to ERROR instead; otherwise retry_count++ on entry to RETRAIN/REPAIR.
//   - pm_req L1/L2 with no error -> L1/L2 with a pm_ack pulse; an error in the same cycle wins.
//   - retry_count clears after STABLE_CYC consecutive ACTIVE cycles.
//  RETRAIN exits to ACTIVE on trn; REPAIR exits to ACTIVE on repair. Both timeout to ERROR.
//  L1 -start-> MBTRAIN; L2 -start-> SBINIT.
//  ERROR -start-> RESET. Reaching RESET this way restores module_en to all ones and clears retry_count;
//   timeout_module persists until rst_n.
//  phy_cmd by state: SBINIT 01, MBINIT 02, CAL 03, MBTRAIN/RETRAIN 04, LINKINIT 05, REPAIR 06, L1 07, L2 08, else 00.
//  phy_reset_req = (state == RESET).
//  State timer clears on every state change and on a masked restart; it saturates, it does not wrap.
//  Async reset mid-operation returns everything to reset values immediately.
// STRUCTURE
//  ucie_pkg additions:
//   - link_state_t gains LINK_L1/LINK_L2 codes if absent.
//   - PM_REQ_L1/PM_REQ_L2 constants.
//   - PHY_CMD_* localparams.
//   - status-bit index constants.
//  Sub-module ucie_mlm_stage_mon (one shared instance):
//   - inputs: NUM_MODULES-wide status slice, module_en, timer_expired.
//   - outputs: all_done, fail_mask, too_few.
// TESTING
//  4 modules all ack per stage -> ACTIVE; phy_cmd sequence 01,02,03,04,05; link_active=1.
//  Module 2 never raises cal; TO_TRAIN=50 -> module_en=4'b1011, timeout_module[2]=1, CAL restarts, then ACTIVE.
//  MIN_MODULES=4, module 0 times out in MBINIT -> ERROR; start -> RESET with module_en=4'hF.
//  tx_ready held low 5 cycles; rx (width 8'h10, speed 8'h04) arrives first; cfg 8'h20/8'h08
//   -> tx_valid stays asserted; negotiated 8'h10/8'h04; MBINIT entered after tx_ready.
//  Four back-to-back CRC errors in ACTIVE with retrain success -> RETRAIN x3, then ERROR; retry_count=3.
//  pm_req=01 in ACTIVE -> L1, pm_ack pulse, phy_cmd=07; start -> MBTRAIN -> LINKINIT -> ACTIVE.

Source files
------------

// File: rtl/ucie_mlink_manager_pkg.sv
// Shared types and constants for the multi-module UCIe link manager.
package ucie_mlink_manager_pkg;

    typedef enum logic [3:0] {
        LINK_RESET    = 4'd0,
        LINK_SBINIT   = 4'd1,
        LINK_PARAM    = 4'd2,
        LINK_MBINIT   = 4'd3,
        LINK_CAL      = 4'd4,
        LINK_MBTRAIN  = 4'd5,
        LINK_LINKINIT = 4'd6,
        LINK_ACTIVE   = 4'd7,
        LINK_RETRAIN  = 4'd8,
        LINK_REPAIR   = 4'd9,
        LINK_L1       = 4'd10,
        LINK_L2       = 4'd11,
        LINK_ERROR    = 4'd15
    } link_state_t;

    localparam logic [1:0] PM_REQ_L1 = 2'b01;
    localparam logic [1:0] PM_REQ_L2 = 2'b10;

    localparam logic [7:0] PHY_CMD_NONE     = 8'h00;
    localparam logic [7:0] PHY_CMD_SBINIT   = 8'h01;
    localparam logic [7:0] PHY_CMD_MBINIT   = 8'h02;
    localparam logic [7:0] PHY_CMD_CAL      = 8'h03;
    localparam logic [7:0] PHY_CMD_TRAIN    = 8'h04;
    localparam logic [7:0] PHY_CMD_LINKINIT = 8'h05;
    localparam logic [7:0] PHY_CMD_REPAIR   = 8'h06;
    localparam logic [7:0] PHY_CMD_L1       = 8'h07;
    localparam logic [7:0] PHY_CMD_L2       = 8'h08;

    localparam int ST_MBRDY   = 0;
    localparam int ST_CAL     = 1;
    localparam int ST_TRN     = 2;
    localparam int ST_LINKRDY = 3;
    localparam int ST_REPAIR  = 4;

    localparam logic [7:0] PARAM_MAGIC = 8'hA5;

    function automatic link_state_t next_train(link_state_t s);
        case (s)
            LINK_SBINIT:  return LINK_PARAM;
            LINK_MBINIT:  return LINK_CAL;
            LINK_CAL:     return LINK_MBTRAIN;
            LINK_MBTRAIN: return LINK_LINKINIT;
            default:      return LINK_ACTIVE;
        endcase
    endfunction

    function automatic logic [7:0] min8(logic [7:0] a, logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ucie_mlink_manager_if.sv
// Sideband parameter exchange: outbound tx channel and inbound rx channel.
interface ucie_mlink_manager_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/ucie_mlm_stage_mon.sv
// Per-stage completion monitor: done, timed-out modules, and survivor check.
module ucie_mlm_stage_mon #(
    parameter int N   = 4,
    parameter int MIN = 1
) (
    input  logic [N-1:0] stat,
    input  logic [N-1:0] en,
    input  logic         expired,
    output logic         all_done,
    output logic [N-1:0] fail_mask,
    output logic         too_few
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  keep;
    logic [CW-1:0] cnt;

    assign all_done  = &(stat | ~en);
    assign fail_mask = expired ? (en & ~stat) : '0;
    assign keep      = en & ~fail_mask;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++)
            cnt = cnt + CW'(keep[i]);
        too_few = int'(cnt) < MIN;
    end
endmodule

// File: rtl/ucie_mlink_manager.sv
// Shared training FSM driving several PHY modules, with timeout masking,
// sideband parameter negotiation, bounded recovery and L1/L2 handling.
module ucie_mlink_manager
    import ucie_mlink_manager_pkg::*;
#(
    parameter int NUM_MODULES = 4,
    parameter int MIN_MODULES = 1,
    parameter int TMR_W       = 24,
    parameter int TO_INIT     = 100000,
    parameter int TO_TRAIN    = 2000000,
    parameter int RETRY_MAX   = 3,
    parameter int STABLE_CYC  = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     link_train_start,
    input  logic [7:0]               cfg_max_width,
    input  logic [7:0]               cfg_max_speed,
    input  logic [NUM_MODULES-1:0]   phy_reset_ack,
    input  logic [NUM_MODULES*8-1:0] phy_status,
    output logic [7:0]               phy_cmd,
    output logic                     phy_reset_req,
    output logic [NUM_MODULES-1:0]   module_en,
    ucie_mlink_manager_if.master     prm,
    input  logic [7:0]               error_vector,
    input  logic [1:0]               pm_req,
    output logic                     pm_ack,
    output logic [3:0]               link_state,
    output logic                     link_active,
    output logic [7:0]               negotiated_width,
    output logic [7:0]               negotiated_speed,
    output logic [2:0]               retry_count,
    output logic [NUM_MODULES-1:0]   timeout_module
);
    localparam int SW = $clog2(STABLE_CYC + 1);

    link_state_t            state, nxt;
    logic [TMR_W-1:0]       timer;
    logic [SW-1:0]          stable_cnt;
    logic [NUM_MODULES-1:0] stat, fail_mask;
    logic [7:0]             cfg_w, cfg_s, rem_w, rem_s, en_pad;
    logic                   expired, all_done, too_few, is_init, use_ack;
    logic                   mask_hit, retry_inc, pm_go;
    logic                   tx_done, rx_done, tx_hs, rx_hs, cap_d;
    int                     sel;

    assign tx_hs = prm.tx_valid & prm.tx_ready;
    assign rx_hs = prm.rx_valid & prm.rx_ready;

    always_comb begin
        use_ack = 1'b0;
        is_init = 1'b0;
        sel     = ST_MBRDY;
        case (state)
            LINK_SBINIT:   begin use_ack = 1'b1; is_init = 1'b1; end
            LINK_PARAM:    is_init = 1'b1;
            LINK_MBINIT:   begin sel = ST_MBRDY; is_init = 1'b1; end
            LINK_CAL:      sel = ST_CAL;
            LINK_MBTRAIN,
            LINK_RETRAIN:  sel = ST_TRN;
            LINK_LINKINIT: begin sel = ST_LINKRDY; is_init = 1'b1; end
            LINK_REPAIR:   sel = ST_REPAIR;
            default:       ;
        endcase
        for (int i = 0; i < NUM_MODULES; i++)
            stat[i] = use_ack ? phy_reset_ack[i] : phy_status[i*8 + sel];
        expired = timer >= (is_init ? TMR_W'(TO_INIT) : TMR_W'(TO_TRAIN));
    end

    ucie_mlm_stage_mon #(.N(NUM_MODULES), .MIN(MIN_MODULES)) u_mon (
        .stat      (stat),
        .en        (module_en),
        .expired   (expired),
        .all_done  (all_done),
        .fail_mask (fail_mask),
        .too_few   (too_few)
    );

    always_comb begin
        nxt       = state;
        mask_hit  = 1'b0;
        retry_inc = 1'b0;
        pm_go     = 1'b0;
        unique case (state)
            LINK_RESET:
                if (link_train_start) nxt = LINK_SBINIT;
            LINK_SBINIT, LINK_MBINIT, LINK_CAL, LINK_MBTRAIN, LINK_LINKINIT:
                if (all_done)     nxt = next_train(state);
                else if (expired) begin
                    if (too_few) nxt = LINK_ERROR;
                    else         mask_hit = 1'b1;
                end
            LINK_PARAM:
                if ((tx_done | tx_hs) && (rx_done | rx_hs)) nxt = LINK_MBINIT;
                else if (expired) nxt = LINK_ERROR;
            LINK_ACTIVE:
                if (|error_vector) begin
                    if (|error_vector[7:2] || retry_count == 3'(RETRY_MAX))
                        nxt = LINK_ERROR;
                    else begin
                        retry_inc = 1'b1;
                        nxt = error_vector[0] ? LINK_RETRAIN : LINK_REPAIR;
                    end
                end else if (pm_req == PM_REQ_L1) begin
                    nxt   = LINK_L1;
                    pm_go = 1'b1;
                end else if (pm_req == PM_REQ_L2) begin
                    nxt   = LINK_L2;
                    pm_go = 1'b1;
                end
            LINK_RETRAIN, LINK_REPAIR:
                if (all_done)     nxt = LINK_ACTIVE;
                else if (expired) nxt = LINK_ERROR;
            LINK_L1:    if (link_train_start) nxt = LINK_MBTRAIN;
            LINK_L2:    if (link_train_start) nxt = LINK_SBINIT;
            LINK_ERROR: if (link_train_start) nxt = LINK_RESET;
            default:    nxt = LINK_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= LINK_RESET;
            timer            <= '0;
            stable_cnt       <= '0;
            module_en        <= '1;
            timeout_module   <= '0;
            retry_count      <= '0;
            cfg_w            <= '0;
            cfg_s            <= '0;
            rem_w            <= '0;
            rem_s            <= '0;
            negotiated_width <= '0;
            negotiated_speed <= '0;
            tx_done          <= 1'b0;
            rx_done          <= 1'b0;
            cap_d            <= 1'b0;
            pm_ack           <= 1'b0;
        end else begin
            state  <= nxt;
            pm_ack <= pm_go;
            if (nxt != state || mask_hit) timer <= '0;
            else if (timer != '1)          timer <= timer + 1'b1;
            if (mask_hit) begin
                module_en      <= module_en & ~fail_mask;
                timeout_module <= timeout_module | fail_mask;
            end
            if (state != LINK_ACTIVE)                   stable_cnt <= '0;
            else if (stable_cnt != SW'(STABLE_CYC - 1)) stable_cnt <= stable_cnt + 1'b1;
            if (state == LINK_ERROR && nxt == LINK_RESET) begin
                module_en   <= '1;
                retry_count <= '0;
            end else if (retry_inc)
                retry_count <= retry_count + 1'b1;
            else if (state == LINK_ACTIVE && stable_cnt == SW'(STABLE_CYC - 1))
                retry_count <= '0;
            if (state == LINK_RESET && nxt != LINK_RESET) begin
                cfg_w <= cfg_max_width;
                cfg_s <= cfg_max_speed;
            end
            tx_done <= (state == LINK_PARAM) && (tx_done | tx_hs);
            rx_done <= (state == LINK_PARAM) && (rx_done | rx_hs);
            if (rx_hs) begin
                rem_w <= prm.rx_data[31:24];
                rem_s <= prm.rx_data[23:16];
            end
            // negotiation lands one cycle after the captured remote values
            cap_d <= rx_hs;
            if (cap_d) begin
                negotiated_width <= min8(cfg_w, rem_w);
                negotiated_speed <= min8(cfg_s, rem_s);
            end
        end
    end

    always_comb begin
        en_pad = '1;
        en_pad[NUM_MODULES-1:0] = module_en;
    end

    assign prm.tx_data  = {cfg_w, cfg_s, en_pad, PARAM_MAGIC};
    assign prm.tx_valid = (state == LINK_PARAM) && !tx_done;
    assign prm.rx_ready = (state == LINK_PARAM) && !rx_done;

    always_comb begin
        phy_cmd = PHY_CMD_NONE;
        case (state)
            LINK_SBINIT:   phy_cmd = PHY_CMD_SBINIT;
            LINK_MBINIT:   phy_cmd = PHY_CMD_MBINIT;
            LINK_CAL:      phy_cmd = PHY_CMD_CAL;
            LINK_MBTRAIN,
            LINK_RETRAIN:  phy_cmd = PHY_CMD_TRAIN;
            LINK_LINKINIT: phy_cmd = PHY_CMD_LINKINIT;
            LINK_REPAIR:   phy_cmd = PHY_CMD_REPAIR;
            LINK_L1:       phy_cmd = PHY_CMD_L1;
            LINK_L2:       phy_cmd = PHY_CMD_L2;
            default:       phy_cmd = PHY_CMD_NONE;
        endcase
    end

    assign link_state    = state;
    assign link_active   = (state == LINK_ACTIVE);
    assign phy_reset_req = (state == LINK_RESET);
endmodule
